ram64_arbiter: RTL and testbench
================================

// Module: ram64_arbiter
// PURPOSE
//  Sequencer/arbiter that shares one ram64 (64 x 16, async read, clocked write) between two requesters A and B.
//  - Round-robin grant, one access per cycle.
//  - Reads return registered data one cycle after grant.
//  - Built-in clear sequencer writes CLEAR_VAL to all 64 words on command.
//  - Sits between the ram64 instance and its users; it is the only driver of the ram64 in/load/address pins.
// PARAMETERS
//  WIDTH      16     data width; must match ram64 word width
//  AW         6      address width; sweep length is 2**AW = 64 words
//  CLEAR_VAL  16'h0  value written to every word during a clear sweep
// PORTS
//  clk          in   1      system clock; all state changes on rising edge
//  rst_n        in   1      synchronous reset, active low
//  req_a        in   1      A request; held with its fields until gnt_a
//  we_a         in   1      A: 1 = write, 0 = read
//  addr_a       in   AW     A word address
//  wdata_a      in   WIDTH  A write data
//  gnt_a        out  1      A request accepted this cycle (combinational)
//  rvalid_a     out  1      A read data valid (one-cycle pulse)
//  rdata_a      out  WIDTH  A read data; holds until the next A read
//  req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b   same as A, for requester B
//  clear_start  in   1      start clear sweep; sampled in IDLE only
//  busy         out  1      clear sweep in progress
//  clear_done   out  1      one-cycle pulse after the last sweep write
//  ram_in       out  WIDTH  to ram64 in
//  ram_load     out  1      to ram64 load
//  ram_address  out  AW     to ram64 address
//  ram_out      in   WIDTH  from ram64 out (combinational read)
// BEHAVIOUR
//  Reset values (while rst_n = 0 at an edge):
//  - state = IDLE, cnt = 0, last = B (A wins first contention).
//  - rvalid_a/b = 0, rdata_a/b = 0, busy = 0, clear_done = 0.
//  - RAM contents are not touched.
//  IDLE, grant (combinational):
//  - Only one of req_a/req_b high: that requester is granted.
//  - Both high: the requester other than last is granted; last updates to the winner at the edge.
//  - No request: gnt_a = gnt_b = 0, ram_load = 0, ram_address = addr_a, ram_in = wdata_a.
//  IDLE, granted access (winner W):
//  - ram_address = addr_W, ram_in = wdata_W, ram_load = we_W.
//  - Write: takes effect at this edge; no rvalid.
//  - Read: rdata_W <= ram_out at this edge; rvalid_W = 1 for the next cycle only.
//  - Read latency is 1 cycle; throughput is 1 access/cycle; back-to-back grants are allowed.
//  clear_start = 1 in IDLE:
//  - No grants this cycle.
//  - state <= CLEAR, cnt <= 0.
//  CLEAR:
//  - busy = 1, gnt_a = gnt_b = 0, ram_load = 1, ram_address = cnt, ram_in = CLEAR_VAL.
//  - cnt increments each cycle.
//  - On the cycle with cnt = 63: state <= IDLE, cnt <= 0, clear_done = 1 the next cycle.
//  - Total busy time is exactly 64 cycles. clear_start is ignored during CLEAR.
//  - Pending requests wait and are arbitrated normally in the first IDLE cycle.
//  - last is unchanged by CLEAR.
//  Boundaries:
//  - cnt wraps from 63 to 0 only via the exit transition.
//  - Read and write to the same address in consecutive cycles: the read sees the new data.
//  - Reset mid-CLEAR aborts the sweep: words already written stay CLEAR_VAL, the rest are unchanged, state = IDLE.
//  - Reset mid-read: the pending rvalid is dropped.
//  - addr/we/wdata changing while req is high and not yet granted are protocol violations; the bench asserts on them.
// TESTING
//  1. Reset, then B writes addr 5 = 16'h1234 (gnt_b in cycle 1).
//     A reads addr 5 in cycle 2 -> rvalid_a in cycle 3, rdata_a = 16'h1234.
//  2. After reset, req_a and req_b held high (both reads) for 4 cycles -> grants A,B,A,B.
//     rvalid alternates one cycle later.
//  3. Write addr 63 = 16'hBEEF, then pulse clear_start:
//     -> busy high for 64 cycles, clear_done pulses once, no grants while busy.
//     -> a later read of addr 63 returns 16'h0000.
//  4. req_a asserted in the same cycle as clear_start:
//     -> gnt_a stays 0 throughout busy, then gnt_a = 1 in the first cycle after busy falls.
//  5. rst_n low at CLEAR cycle 10 (cnt = 10), after addr 40 was preloaded with 16'h5555:
//     -> busy = 0 after reset, addr 0..9 read 0, addr 40 reads 16'h5555.
//  6. A streams reads of addr 0..7 (preloaded 1..8) with B idle:
//     -> gnt_a every cycle; rvalid_a high 8 consecutive cycles; rdata_a = 1..8 in order.

Source files
------------

// File: rtl/ram64_arbiter.sv
// Round-robin A/B arbiter and clear sequencer in front of a single ram64 (64 x 16, async read).
// Reads return 1 cycle after grant; requesters hold req until gnt, and no grants are given while clearing.
module ram64_arbiter #(
  parameter int               WIDTH     = 16,
  parameter int               AW        = 6,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic             gnt_a,
  output logic             rvalid_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] wdata_b,
  output logic             gnt_b,
  output logic             rvalid_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clear_start,
  output logic             busy,
  output logic             clear_done,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_out
);

  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_CLEAR = 1'b1;
  localparam logic          SEL_A    = 1'b0;
  localparam logic          SEL_B    = 1'b1;
  localparam logic [AW-1:0] CNT_LAST = '1;

  typedef struct packed {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] dat;
  } acc_t;

  logic [0:0]       state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             rvalid_a_q, rvalid_a_d;
  logic             rvalid_b_q, rvalid_b_d;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
  logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
  logic             clear_done_q, clear_done_d;

  acc_t acc_a, acc_b, acc_sel;
  logic arb_en, gnt_a_c, gnt_b_c;

  // A clear_start cycle arbitrates nobody, so the sweep owns the RAM from its first edge.
  always_comb begin
    acc_a   = {we_a, addr_a, wdata_a};
    acc_b   = {we_b, addr_b, wdata_b};
    arb_en  = (state_q == ST_IDLE) && !clear_start;
    gnt_a_c = arb_en && req_a && (!req_b || (last_q == SEL_B));
    gnt_b_c = arb_en && req_b && (!req_a || (last_q == SEL_A));
    acc_sel = gnt_b_c ? acc_b : acc_a;
  end

  // A write is suppressed while reset is held so reset never disturbs RAM contents.
  always_comb begin
    ram_address = acc_sel.addr;
    ram_in      = acc_sel.dat;
    ram_load    = (gnt_a_c || gnt_b_c) && acc_sel.we;
    if (state_q == ST_CLEAR) begin
      ram_address = cnt_q;
      ram_in      = CLEAR_VAL;
      ram_load    = 1'b1;
    end
    if (!rst_n) begin
      ram_load = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    clear_done_d = 1'b0;
    rvalid_a_d   = gnt_a_c && !we_a;
    rvalid_b_d   = gnt_b_c && !we_b;
    rdata_a_d    = rvalid_a_d ? ram_out : rdata_a_q;
    rdata_b_d    = rvalid_b_d ? ram_out : rdata_b_q;
    if (gnt_a_c) begin
      last_d = SEL_A;
    end else if (gnt_b_c) begin
      last_d = SEL_B;
    end
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          clear_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_q       <= SEL_B;
      rvalid_a_q   <= 1'b0;
      rvalid_b_q   <= 1'b0;
      rdata_a_q    <= '0;
      rdata_b_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      rvalid_a_q   <= rvalid_a_d;
      rvalid_b_q   <= rvalid_b_d;
      rdata_a_q    <= rdata_a_d;
      rdata_b_q    <= rdata_b_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign gnt_a      = gnt_a_c;
  assign gnt_b      = gnt_b_c;
  assign rvalid_a   = rvalid_a_q;
  assign rvalid_b   = rvalid_b_q;
  assign rdata_a    = rdata_a_q;
  assign rdata_b    = rdata_b_q;
  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Directed bench for ram64_arbiter with a behavioural ram64 and read-data scoreboards per requester.
module tb_ram64_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, we_a, req_b, we_b, clear_start;
  logic [5:0]  addr_a, addr_b, ram_address;
  logic [15:0] wdata_a, wdata_b, rdata_a, rdata_b, ram_in, ram_out;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, busy, clear_done, ram_load;

  always #5 clk = ~clk;

  ram64_arbiter #(.WIDTH(16), .AW(6), .CLEAR_VAL(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  // Behavioural ram64: clocked write, combinational read.
  logic [15:0] mem [64];
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  int cmp_cnt = 0;
  int mis_cnt = 0;
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    cmp_cnt++;
    assert (obs === want) else begin
      mis_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Scoreboard: every rvalid pulse must match the oldest pending expected read.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n && rvalid_a) begin
      check("sb_a_pending", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("sb_rdata_a", rdata_a, e);
      end
    end
    if (rst_n && rvalid_b) begin
      check("sb_b_pending", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("sb_rdata_b", rdata_b, e);
      end
    end
  end

  // Request fields must stay stable while a request waits for its grant.
  bit          pend_a = 1'b0, pend_b = 1'b0;
  logic [22:0] held_a, held_b;
  always begin
    @(negedge clk);
    #2;
    if (rst_n && pend_a) check("proto_hold_a", {we_a, addr_a, wdata_a}, held_a);
    if (rst_n && pend_b) check("proto_hold_b", {we_b, addr_b, wdata_b}, held_b);
    pend_a = rst_n && req_a && !gnt_a;
    pend_b = rst_n && req_b && !gnt_b;
    held_a = {we_a, addr_a, wdata_a};
    held_b = {we_b, addr_b, wdata_b};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_idle();
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    clear_start = 1'b0;
  endtask

  // One access by A (side=0) or B (side=1); waits (bounded) for the grant, checks the rvalid slot.
  task automatic access(input bit side, input bit we, input logic [5:0] addr,
                        input logic [15:0] dat, input logic [15:0] rd_exp);
    int   waits;
    logic g;
    @(negedge clk);
    if (side) begin
      req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = dat;
    end else begin
      req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = dat;
    end
    #1;
    g = side ? gnt_b : gnt_a;
    waits = 0;
    while (!g && waits < 200) begin
      @(negedge clk);
      #1;
      g = side ? gnt_b : gnt_a;
      waits++;
    end
    check(side ? "acc_gnt_b" : "acc_gnt_a", g, 1);
    if (!we) begin
      if (side) exp_b.push_back(rd_exp);
      else exp_a.push_back(rd_exp);
    end
    @(negedge clk);
    if (side) req_b = 1'b0;
    else req_a = 1'b0;
    check(side ? "acc_rvalid_b" : "acc_rvalid_a", side ? rvalid_b : rvalid_a, !we);
  endtask

  initial begin
    int busy_n, done_n, done_at, bad, leak, waits;

    // Reset state
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_clear_done", clear_done, 0);
    check("rst_rvalid_a", rvalid_a, 0);
    check("rst_rvalid_b", rvalid_b, 0);
    check("rst_rdata_a", rdata_a, 0);
    check("rst_rdata_b", rdata_b, 0);
    rst_n = 1'b1;

    // T1: B writes addr 5 in cycle 1, A reads it back in cycle 2
    req_b = 1'b1; we_b = 1'b1; addr_b = 6'd5; wdata_b = 16'h1234;
    #1;
    check("t1_gnt_b", gnt_b, 1);
    check("t1_ram_load", ram_load, 1);
    @(negedge clk);
    req_b = 1'b0; we_b = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd5;
    #1;
    check("t1_gnt_a", gnt_a, 1);
    exp_a.push_back(16'h1234);
    @(negedge clk);
    req_a = 1'b0;
    check("t1_rvalid_a", rvalid_a, 1);
    @(negedge clk);
    check("t1_rvalid_a_drop", rvalid_a, 0);
    check("t1_rdata_a_hold", rdata_a, 16'h1234);

    // T2: both requesters read continuously after reset -> A,B,A,B
    access(1'b1, 1'b1, 6'd7, 16'h0777, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd5;
    req_b = 1'b1; we_b = 1'b0; addr_b = 6'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_gnt_a", gnt_a, (k % 2) == 0);
      check("t2_gnt_b", gnt_b, (k % 2) == 1);
      check("t2_rvalid_a", rvalid_a, (k % 2) == 1);
      check("t2_rvalid_b", rvalid_b, (k > 0) && ((k % 2) == 0));
      if ((k % 2) == 0) exp_a.push_back(16'h1234);
      else exp_b.push_back(16'h0777);
      @(negedge clk);
    end
    req_a = 1'b0; req_b = 1'b0;
    check("t2_rvalid_b_last", rvalid_b, 1);
    check("t2_rvalid_a_last", rvalid_a, 0);

    // T3: write 63, clear sweep, read back cleared word
    access(1'b0, 1'b1, 6'd63, 16'hBEEF, 16'h0);
    access(1'b0, 1'b0, 6'd63, 16'h0, 16'hBEEF);
    @(negedge clk);
    clear_start = 1'b1;
    #1;
    check("t3_no_gnt_on_start", gnt_a | gnt_b, 0);
    @(negedge clk);
    clear_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; bad = 0;
    for (int i = 0; i < 70; i++) begin
      if (busy) begin
        busy_n++;
        if (gnt_a || gnt_b || !ram_load || clear_done || ram_address != 6'(i)) bad++;
      end
      if (clear_done) begin
        done_n++;
        done_at = i;
      end
      @(negedge clk);
    end
    check("t3_busy_cycles", busy_n, 64);
    check("t3_done_pulses", done_n, 1);
    check("t3_done_position", done_at, 64);
    check("t3_sweep_errors", bad, 0);
    access(1'b0, 1'b0, 6'd63, 16'h0, 16'h0000);
    access(1'b1, 1'b0, 6'd0, 16'h0, 16'h0000);

    // T4: A request raised with clear_start waits out the whole sweep
    access(1'b0, 1'b1, 6'd63, 16'hBEEF, 16'h0);
    @(negedge clk);
    clear_start = 1'b1;
    req_a = 1'b1; we_a = 1'b0; addr_a = 6'd63;
    #1;
    check("t4_gnt_on_start", gnt_a, 0);
    @(negedge clk);
    clear_start = 1'b0;
    busy_n = 0; leak = 0; waits = 0;
    while (waits < 100) begin
      #1;
      if (busy) begin
        busy_n++;
        if (gnt_a) leak++;
      end else if (busy_n > 0) begin
        break;
      end
      @(negedge clk);
      waits++;
    end
    check("t4_busy_cycles", busy_n, 64);
    check("t4_gnt_leak", leak, 0);
    check("t4_gnt_after_busy", gnt_a, 1);
    check("t4_clear_done", clear_done, 1);
    exp_a.push_back(16'h0000);
    @(negedge clk);
    req_a = 1'b0;
    check("t4_rvalid_a", rvalid_a, 1);

    // T6: A streams reads of 0..7 back to back
    for (int i = 0; i < 8; i++) access(1'b0, 1'b1, 6'(i), 16'(i + 1), 16'h0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      req_a = 1'b1; we_a = 1'b0; addr_a = 6'(k);
      #1;
      check("t6_gnt_a", gnt_a, 1);
      check("t6_rvalid_a", rvalid_a, k > 0);
      exp_a.push_back(16'(k + 1));
      @(negedge clk);
    end
    req_a = 1'b0;
    check("t6_rvalid_a_last", rvalid_a, 1);
    @(negedge clk);
    check("t6_rvalid_a_drop", rvalid_a, 0);
    check("t6_rdata_a_hold", rdata_a, 16'h0008);

    // T5: reset at sweep cycle 10 aborts the clear
    access(1'b0, 1'b1, 6'd8, 16'h0009, 16'h0);
    access(1'b0, 1'b1, 6'd9, 16'h000A, 16'h0);
    access(1'b1, 1'b1, 6'd10, 16'h7777, 16'h0);
    access(1'b1, 1'b1, 6'd40, 16'h5555, 16'h0);
    @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_busy_at_10", busy, 1);
    check("t5_addr_at_10", ram_address, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_busy_in_reset", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_busy_after_reset", busy, 0);
    for (int i = 0; i < 10; i++) access(1'b0, 1'b0, 6'(i), 16'h0, 16'h0000);
    access(1'b0, 1'b0, 6'd10, 16'h0, 16'h7777);
    access(1'b1, 1'b0, 6'd40, 16'h0, 16'h5555);

    repeat (2) @(negedge clk);
    check("sb_a_drained", exp_a.size(), 0);
    check("sb_b_drained", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
